// File: rtl/ita_disp_drv.sv
// ============================================================================
// Module   : ita_disp_drv
// Purpose  : Pad driver for a 12-digit 14-segment scanned display. Registers
//            the scan multiplexer's digit select and segment pattern, forces a
//            blanking interval on every input change to suppress ghosting,
//            applies PWM brightness, flags illegal select codes and applies
//            pad polarity. All outputs are registered.
// Ports    : clk       - sole clock, rising edge
//            rst_n     - asynchronous active-low reset
//            sel_in    - one-hot digit select from the scan multiplexer
//            segm_in   - segment pattern, 1 = lit
//            en        - display enable, 0 = all dark
//            bright    - PWM duty numerator, 0 = dark
//            sel_out   - pad-level digit select
//            segm_out  - pad-level segments
//            err       - sticky illegal-select flag, cleared only by reset
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ita_disp_drv #(
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned PWM_BITS       = 4,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [11:0]         sel_in,
    input  logic [13:0]         segm_in,
    input  logic                en,
    input  logic [PWM_BITS-1:0] bright,
    output logic [11:0]         sel_out,
    output logic [13:0]         segm_out,
    output logic                err
);

    localparam logic [1:0] c_ST_OFF   = 2'd0;
    localparam logic [1:0] c_ST_BLANK = 2'd1;
    localparam logic [1:0] c_ST_DRIVE = 2'd2;

    localparam logic [3:0]          c_BLANK_LOAD = 4'(BLANK_CYCLES);
    localparam logic [PWM_BITS-1:0] c_PWM_MAX    = '1;
    localparam logic [11:0]         c_SEL_POL    = {12{SEL_ACTIVE_LOW}};
    localparam logic [13:0]         c_SEG_POL    = {14{SEG_ACTIVE_LOW}};

    // Registered state
    logic [1:0]          state_q,     state_d;
    logic [3:0]          blank_cnt_q, blank_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic [PWM_BITS-1:0] bright_q,    bright_d;
    logic [25:0]         in_q;
    logic [25:0]         last_q;
    logic                err_q,       err_d;
    logic [11:0]         sel_out_q,   sel_out_d;
    logic [13:0]         segm_out_q,  segm_out_d;

    logic [11:0] w_in_sel;
    logic [13:0] w_in_segm;
    logic        w_change;
    logic        w_legal;
    logic        w_lit;

    assign w_in_sel  = in_q[25:14];
    assign w_in_segm = in_q[13:0];

    // Any difference over select and segments forces a fresh blanking interval,
    // so a new select can never appear with the previous digit's segments.
    assign w_change  = (in_q != last_q);
    assign w_legal   = $onehot(w_in_sel);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_ST_OFF;
            blank_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            bright_q    <= '0;
            in_q        <= '0;
            last_q      <= '0;
            err_q       <= 1'b0;
            sel_out_q   <= c_SEL_POL;
            segm_out_q  <= c_SEG_POL;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            bright_q    <= bright_d;
            in_q        <= {sel_in, segm_in};
            last_q      <= in_q;
            err_q       <= err_d;
            sel_out_q   <= sel_out_d;
            segm_out_q  <= segm_out_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        bright_d    = bright_q;

        if (!en) begin
            state_d = c_ST_OFF;
        end else begin
            case (state_q)
                c_ST_OFF: begin
                    state_d     = c_ST_BLANK;
                    blank_cnt_d = c_BLANK_LOAD;
                end
                c_ST_BLANK: begin
                    if (w_change) begin
                        blank_cnt_d = c_BLANK_LOAD;
                    end else if (blank_cnt_q == 4'd0) begin
                        state_d   = c_ST_DRIVE;
                        pwm_cnt_d = '0;
                        bright_d  = bright;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 4'd1;
                    end
                end
                c_ST_DRIVE: begin
                    if (w_change) begin
                        state_d     = c_ST_BLANK;
                        blank_cnt_d = c_BLANK_LOAD;
                    end else begin
                        pwm_cnt_d = pwm_cnt_q + 1'b1;
                        // Brightness only updates at a period boundary so a
                        // pulse already in progress is never cut short.
                        if (pwm_cnt_q == c_PWM_MAX) begin
                            bright_d = bright;
                        end
                    end
                end
                default: begin
                    state_d = c_ST_OFF;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic. Evaluated on the next-state values so the pads reflect the
    // state being entered on this edge (e.g. dark on the same edge that enters
    // BLANK or OFF).
    // ------------------------------------------------------------------------
    always_comb begin
        w_lit      = (state_d == c_ST_DRIVE) && (pwm_cnt_d < bright_d) && w_legal;
        sel_out_d  = (w_lit ? w_in_sel  : 12'h000)  ^ c_SEL_POL;
        segm_out_d = (w_lit ? w_in_segm : 14'h0000) ^ c_SEG_POL;
        // Select legality is only judged while the display is active; with the
        // display off the registered input is still the all-zero reset value
        // or an idle multiplexer, which is not a fault.
        err_d      = err_q | (!w_legal && (state_q != c_ST_OFF));
    end

    assign sel_out  = sel_out_q;
    assign segm_out = segm_out_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ita_disp_drv.sv
// ============================================================================
// Module   : tb_ita_disp_drv
// Purpose  : Self-checking bench for ita_disp_drv. One instance with default
//            parameters, a second with inverted polarities and no blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ita_disp_drv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  bright;
    logic [11:0] sel_in;
    logic [13:0] segm_in;
    logic [11:0] sel_out,  sel_out2;
    logic [13:0] segm_out, segm_out2;
    logic        err, err2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ita_disp_drv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_in   (sel_in),
        .segm_in  (segm_in),
        .en       (en),
        .bright   (bright),
        .sel_out  (sel_out),
        .segm_out (segm_out),
        .err      (err)
    );

    ita_disp_drv #(
        .BLANK_CYCLES   (0),
        .PWM_BITS       (4),
        .SEL_ACTIVE_LOW (1'b0),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_in   (sel_in),
        .segm_in  (segm_in),
        .en       (en),
        .bright   (bright),
        .sel_out  (sel_out2),
        .segm_out (segm_out2),
        .err      (err2)
    );

    typedef struct {
        logic [11:0] sel;
        logic [13:0] segm;
        logic [3:0]  br;
        int          lead;   // leading dark samples after the change
        int          lit;    // lit samples in the 35-sample window
    } vec_t;

    typedef struct {
        int lead;
        int lit;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_dark();
        return (sel_out == 12'hFFF) && (segm_out == 14'h0000);
    endfunction

    function automatic bit is_lit_as(input logic [11:0] s, input logic [13:0] g);
        return (sel_out == ~s) && (segm_out == g);
    endfunction

    initial begin
        int   lead, lit, bad, cnt;
        bit   in_lead, found;
        exp_t e;

        // 3 dark + 32 samples starting at pwm 0 -> lit = 2 * bright
        vecs[0] = '{12'h002, 14'h3BC0, 4'd15,  3, 30};
        vecs[1] = '{12'h002, 14'h0155, 4'd4,   3,  8};
        vecs[2] = '{12'h800, 14'h2AAA, 4'd9,   3, 18};
        vecs[3] = '{12'h010, 14'h1234, 4'd0,  35,  0};
        vecs[4] = '{12'h001, 14'h3FFF, 4'd1,   3,  2};
        vecs[5] = '{12'h004, 14'h3BC0, 4'd15,  3, 30};

        // ---------------- reset and first light-up ----------------
        rst_n   = 1'b0;
        en      = 1'b1;
        bright  = 4'd15;
        sel_in  = 12'h001;
        segm_in = 14'h3BC0;
        #12;
        check("rst_sel_out",   32'(sel_out),   32'h0FFF);
        check("rst_segm_out",  32'(segm_out),  32'h0000);
        check("rst_err",       32'(err),       32'h0);
        check("rst2_sel_out",  32'(sel_out2),  32'h0000);
        check("rst2_segm_out", 32'(segm_out2), 32'h3FFF);
        check("rst2_err",      32'(err2),      32'h0);
        step();
        rst_n = 1'b1;

        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (is_dark()) cnt++;
        end
        check("startup_dark", 32'(cnt), 32'd4);
        step();
        check("first_lit_sel",  32'(sel_out),  32'h0FFE);
        check("first_lit_segm", 32'(segm_out), 32'h3BC0);
        lit = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (is_lit_as(12'h001, 14'h3BC0)) lit++;
        end
        check("duty_15_of_16", 32'(lit), 32'd15);
        check("err_legal", 32'(err), 32'h0);

        // ---------------- table-driven change / PWM vectors ----------------
        for (int v = 0; v < 6; v++) begin
            sel_in  = vecs[v].sel;
            segm_in = vecs[v].segm;
            bright  = vecs[v].br;
            sb.push_back('{vecs[v].lead, vecs[v].lit});
            step();   // capture edge still shows the previous input
            lead = 0; lit = 0; bad = 0; in_lead = 1'b1;
            for (int c = 0; c < 35; c++) begin
                step();
                if (is_dark()) begin
                    if (in_lead) lead++;
                end else begin
                    in_lead = 1'b0;
                    if (is_lit_as(vecs[v].sel, vecs[v].segm)) lit++;
                    else bad++;
                end
            end
            e = sb.pop_front();
            check($sformatf("vec%0d_lead_dark", v), 32'(lead), 32'(e.lead));
            check($sformatf("vec%0d_lit", v),       32'(lit),  32'(e.lit));
            check($sformatf("vec%0d_ghost", v),     32'(bad),  32'd0);
        end

        // ---------------- mid-period brightness change ----------------
        sel_in  = 12'h001;
        segm_in = 14'h3BC0;
        bright  = 4'd4;
        step();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (is_dark()) cnt++;
        end
        check("br4_blank", 32'(cnt), 32'd3);
        lit = 0;
        for (int i = 0; i < 3; i++) begin   // pwm 0..2
            step();
            if (is_lit_as(12'h001, 14'h3BC0)) lit++;
        end
        bright = 4'd12;
        for (int i = 0; i < 13; i++) begin  // pwm 3..15
            step();
            if (is_lit_as(12'h001, 14'h3BC0)) lit++;
        end
        check("br_period_kept_4", 32'(lit), 32'd4);
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (is_lit_as(12'h001, 14'h3BC0)) lit++;
        end
        check("br_next_period_12", 32'(lit), 32'd12);
        bright = 4'd0;
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (!is_dark()) lit++;
        end
        check("br0_dark", 32'(lit), 32'd0);

        // ---------------- illegal select ----------------
        bright = 4'd15;
        sel_in = 12'h003;
        step();
        check("err_not_yet", 32'(err), 32'h0);
        bad = (sel_out == 12'hFFC) ? 1 : 0;
        sel_in = 12'h001;
        step();
        check("err_set", 32'(err), 32'h1);
        if (sel_out == 12'hFFC) bad++;
        lit = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sel_out == 12'hFFC) bad++;
            if (is_lit_as(12'h001, 14'h3BC0)) lit++;
        end
        check("illegal_never_lit", 32'(bad), 32'd0);
        check("recover_lit", 32'(lit), 32'd35);
        check("err_sticky", 32'(err), 32'h1);

        // ---------------- enable drop / raise ----------------
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (is_lit_as(12'h001, 14'h3BC0)) found = 1'b1;
        end
        check("lit_before_en_drop", 32'(found), 32'h1);
        en = 1'b0;
        step();
        check("en_drop_dark", 32'(is_dark()), 32'h1);
        step();
        step();
        en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (is_dark()) cnt++;
        end
        check("en_rise_dark3", 32'(cnt), 32'd3);
        step();
        check("en_rise_lit", 32'(is_lit_as(12'h001, 14'h3BC0)), 32'h1);

        // ---------------- reset in the middle of BLANK ----------------
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("midblank_rst_dark", 32'(is_dark()), 32'h1);
        check("midblank_rst_err",  32'(err),       32'h0);
        check("midblank_rst_err2", 32'(err2),      32'h0);
        step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (is_dark()) cnt++;
        end
        check("restart_dark", 32'(cnt), 32'd4);
        step();
        check("restart_lit", 32'(is_lit_as(12'h001, 14'h3BC0)), 32'h1);

        // ---------------- inverted polarity, no blanking ----------------
        for (int i = 0; i < 20; i++) step();
        sel_in  = 12'h002;
        segm_in = 14'h0155;
        step();
        step();
        check("pol_dark_sel",  32'(sel_out2),  32'h0000);
        check("pol_dark_segm", 32'(segm_out2), 32'h3FFF);
        step();
        check("pol_lit_sel",   32'(sel_out2),  32'h0002);
        check("pol_lit_segm",  32'(segm_out2), 32'h3EAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
